// File: rtl/lc3_alu_seq.sv
// LC-3 operate-instruction sequencer (ADD/AND/NOT): IR latch, ALU controls, regfile strobes, NZP.
// Optional completed-op counter enabled by defining LC3_ALU_SEQ_PERF_EN.
module lc3_alu_seq #(
  parameter int EXEC_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      ir,
  input  logic             ir_vld,
  output logic             ir_rdy,
  input  logic             flush,
  input  logic [15:0]      bus,
  output logic [1:0]       aluk,
  output logic [5:0]       ir_slice,
  output logic             gate_alu_en,
  output logic [2:0]       sr1_sel,
  output logic [2:0]       sr2_sel,
  output logic [2:0]       dr_sel,
  output logic             ld_reg,
  output logic             ld_cc,
  output logic [2:0]       nzp,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  localparam logic [1:0] CNT_INIT = 2'(EXEC_CYC - 1);

  state_t      state, state_d;
  logic [15:0] ir_q;
  logic [1:0]  cnt, cnt_d;
  logic [3:0]  opc;
  logic        legal, wb_fire;

  assign opc      = ir_q[15:12];
  assign legal    = (opc == 4'b0001) || (opc == 4'b0101) ||
                    ((opc == 4'b1001) && (ir_q[5:0] == 6'h3F));
  assign ir_slice = ir_q[5:0];
  assign sr1_sel  = ir_q[8:6];
  assign sr2_sel  = ir_q[2:0];
  assign dr_sel   = ir_q[11:9];
  assign wb_fire  = (state == WB) && !flush;

  always_comb begin
    aluk = 2'b00;
    if (state != IDLE) begin
      case (opc)
        4'b0101: aluk = 2'b01;
        4'b1001: aluk = 2'b10;
        default: aluk = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ir_rdy      = 1'b0;
    gate_alu_en = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        ir_rdy = 1'b1;
        if (ir_vld) state_d = DECODE;
      end
      DECODE: begin
        if (legal) begin
          state_d = EXEC;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ERR;
        end
      end
      EXEC: begin
        gate_alu_en = 1'b1;
        if (cnt == 2'd0) state_d = WB;
        else             cnt_d   = cnt - 2'd1;
      end
      WB: begin
        gate_alu_en = 1'b1;
        ld_reg      = 1'b1;
        ld_cc       = 1'b1;
        done        = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        illegal = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything; writeback strobes of this cycle are squashed.
    if (flush) begin
      state_d = IDLE;
      ld_reg  = 1'b0;
      ld_cc   = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      ir_q  <= 16'h0;
      nzp   <= 3'b010;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && ir_vld && !flush) ir_q <= ir;
      if (wb_fire) nzp <= {bus[15], bus == 16'h0, !bus[15] && bus != 16'h0};
    end
  end

`ifdef LC3_ALU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       op_cnt <= '0;
    else if (wb_fire) op_cnt <= op_cnt + CNT_W'(1);
  end
`else
  assign op_cnt = '0;
`endif
endmodule

// File: tb/tb_lc3_alu_seq.sv
// Self-checking bench for lc3_alu_seq: directed table, flush/reset corners, random ops vs. a model.
module tb_lc3_alu_seq;
  localparam int EXEC_CYC = 1;
  localparam int CNT_W    = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] ir = '0, bus = '0;
  logic ir_vld = 1'b0, flush = 1'b0;
  logic ir_rdy, gate_alu_en, ld_reg, ld_cc, done, illegal;
  logic [1:0] aluk;
  logic [5:0] ir_slice;
  logic [2:0] sr1_sel, sr2_sel, dr_sel, nzp;
  logic [CNT_W-1:0] op_cnt;

  lc3_alu_seq #(.EXEC_CYC(EXEC_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ir_vld(ir_vld), .ir_rdy(ir_rdy), .flush(flush),
    .bus(bus), .aluk(aluk), .ir_slice(ir_slice), .gate_alu_en(gate_alu_en),
    .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .dr_sel(dr_sel), .ld_reg(ld_reg), .ld_cc(ld_cc),
    .nzp(nzp), .done(done), .illegal(illegal), .op_cnt(op_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [2:0]       exp_nzp = 3'b010;
  logic [CNT_W-1:0] exp_cnt = '0;

  typedef struct {
    int         done_at, ill_at, gate_n, ld_n, ldcc_n;
    logic [1:0] aluk;
    logic [5:0] slice;
    logic [2:0] sr1, sr2, dr;
  } obs_t;

  typedef struct {
    logic [15:0] ir, bus;
    logic        legal;
    logic [1:0]  aluk;
    logic [5:0]  slice;
    logic [2:0]  sr1, sr2, dr, nzp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offer one instruction and observe a fixed window long enough for any EXEC_CYC.
  task automatic do_op(input logic [15:0] ir_v, input logic [15:0] bus_v, output obs_t o);
    o = '{done_at: -1, ill_at: -1, gate_n: 0, ld_n: 0, ldcc_n: 0,
          aluk: 0, slice: 0, sr1: 0, sr2: 0, dr: 0};
    @(negedge clk);
    chk("ir_rdy_before_accept", {31'b0, ir_rdy}, 1);
    ir = ir_v; bus = bus_v; ir_vld = 1'b1;
    @(negedge clk);
    ir_vld = 1'b0;
    o.aluk = aluk; o.slice = ir_slice; o.sr1 = sr1_sel; o.sr2 = sr2_sel; o.dr = dr_sel;
    for (int c = 1; c <= 8; c++) begin
      if (done && o.done_at < 0)   o.done_at = c;
      if (illegal && o.ill_at < 0) o.ill_at = c;
      if (gate_alu_en) o.gate_n++;
      if (ld_reg) o.ld_n++;
      if (ld_cc)  o.ldcc_n++;
      if (c < 8) @(negedge clk);
    end
  endtask

  // Reference: operate-instruction semantics straight from the ISA rules.
  task automatic model_check(input string nm, input logic [15:0] ir_v, input logic [15:0] bus_v,
                             input obs_t o);
    logic [3:0] op;
    logic lg;
    logic [1:0] ea;
    op = ir_v[15:12];
    lg = (op == 4'd1) || (op == 4'd5) || (op == 4'd9 && ir_v[5:0] == 6'd63);
    ea = (op == 4'd5) ? 2'd1 : (op == 4'd9) ? 2'd2 : 2'd0;
    if (lg) begin
      if ($signed(bus_v) < 0)  exp_nzp = 3'b100;
      else if (bus_v == 0)     exp_nzp = 3'b010;
      else                     exp_nzp = 3'b001;
`ifdef LC3_ALU_SEQ_PERF_EN
      exp_cnt = CNT_W'((int'(exp_cnt) + 1) % (1 << CNT_W));
`endif
      chk({nm, "_aluk"}, {30'b0, o.aluk}, {30'b0, ea});
      chk({nm, "_slice"}, {26'b0, o.slice}, {26'b0, ir_v[5:0]});
      chk({nm, "_sels"}, {23'b0, o.dr, o.sr1, o.sr2}, {23'b0, ir_v[11:9], ir_v[8:6], ir_v[2:0]});
    end
    chk({nm, "_done_at"}, o.done_at, lg ? EXEC_CYC + 2 : -1);
    chk({nm, "_ill_at"}, o.ill_at, lg ? -1 : 2);
    chk({nm, "_gate_n"}, o.gate_n, lg ? EXEC_CYC + 1 : 0);
    chk({nm, "_ld_n"}, {o.ld_n[15:0], o.ldcc_n[15:0]}, lg ? 32'h0001_0001 : 32'h0);
    chk({nm, "_nzp"}, {29'b0, nzp}, {29'b0, exp_nzp});
    chk({nm, "_op_cnt"}, {28'b0, op_cnt}, {28'b0, exp_cnt});
  endtask

  vec_t tbl[5];
  obs_t o;

  initial begin
    tbl[0] = '{16'h167E, 16'hFFFF, 1, 2'b00, 6'h3E, 3'd1, 3'd6, 3'd3, 3'b100};
    tbl[1] = '{16'h5484, 16'h0000, 1, 2'b01, 6'h04, 3'd2, 3'd4, 3'd2, 3'b010};
    tbl[2] = '{16'h9BBF, 16'h0001, 1, 2'b10, 6'h3F, 3'd6, 3'd7, 3'd5, 3'b001};
    tbl[3] = '{16'h9BBE, 16'h1234, 0, 2'b00, 6'h00, 3'd0, 3'd0, 3'd0, 3'b001};
    tbl[4] = '{16'h2000, 16'h0000, 0, 2'b00, 6'h00, 3'd0, 3'd0, 3'd0, 3'b001};

    #12;
    chk("rst_ir_rdy", {31'b0, ir_rdy}, 1);
    chk("rst_nzp", {29'b0, nzp}, 3'b010);
    chk("rst_outs", {26'b0, gate_alu_en, ld_reg, ld_cc, done, illegal, |aluk}, 0);
    chk("rst_sels", {17'b0, dr_sel, sr1_sel, sr2_sel, ir_slice}, 0);
    chk("rst_op_cnt", {28'b0, op_cnt}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].ir, tbl[i].bus, o);
      model_check($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].bus, o);
      chk($sformatf("tbl%0d_nzp_const", i), {29'b0, nzp}, {29'b0, tbl[i].nzp});
      if (tbl[i].legal) begin
        chk($sformatf("tbl%0d_aluk_const", i), {30'b0, o.aluk}, {30'b0, tbl[i].aluk});
        chk($sformatf("tbl%0d_fields_const", i), {17'b0, o.dr, o.sr1, o.sr2, o.slice},
            {17'b0, tbl[i].dr, tbl[i].sr1, tbl[i].sr2, tbl[i].slice});
      end
    end

    // Flush in first EXEC cycle: no writeback, nzp unchanged, idle next cycle.
    @(negedge clk); ir = 16'h167E; bus = 16'h8000; ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    @(negedge clk);
    chk("fl_exec_gate", {31'b0, gate_alu_en}, 1);
    flush = 1'b1;
    #1 chk("fl_exec_strobes", {29'b0, ld_reg, ld_cc, done}, 0);
    @(negedge clk); flush = 1'b0;
    chk("fl_exec_rdy", {31'b0, ir_rdy}, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || ld_reg || gate_alu_en) chk("fl_exec_quiet", 1, 0);
    end
    chk("fl_exec_nzp", {29'b0, nzp}, {29'b0, exp_nzp});
    chk("fl_exec_cnt", {28'b0, op_cnt}, {28'b0, exp_cnt});

    // Flush during WB itself squashes the strobes and the CC load.
    @(negedge clk); ir = 16'h5484; bus = 16'h0000; ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    for (int c = 0; c < EXEC_CYC + 1; c++) @(negedge clk);
    flush = 1'b1;
    #1 chk("fl_wb_strobes", {29'b0, ld_reg, ld_cc, done}, 0);
    @(negedge clk); flush = 1'b0;
    chk("fl_wb_nzp", {29'b0, nzp}, {29'b0, exp_nzp});
    chk("fl_wb_cnt", {28'b0, op_cnt}, {28'b0, exp_cnt});

    // Flush together with ir_vld in IDLE: nothing accepted.
    @(negedge clk); ir = 16'h167E; ir_vld = 1'b1; flush = 1'b1;
    @(negedge clk); ir_vld = 1'b0; flush = 1'b0;
    chk("fl_idle_rdy", {31'b0, ir_rdy}, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || illegal || gate_alu_en) chk("fl_idle_quiet", 1, 0);
    end

    // Reset mid-EXEC: gate drops without a clock edge, CC returns to Z.
    @(negedge clk); ir = 16'h167E; bus = 16'hFFFF; ir_vld = 1'b1;
    @(negedge clk); ir_vld = 1'b0;
    @(negedge clk);
    chk("rst_mid_gate_before", {31'b0, gate_alu_en}, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_gate_after", {31'b0, gate_alu_en}, 0);
    chk("rst_mid_nzp", {29'b0, nzp}, 3'b010);
    chk("rst_mid_rdy", {31'b0, ir_rdy}, 1);
    exp_nzp = 3'b010; exp_cnt = '0;
    @(negedge clk); rst_n = 1'b1;
    do_op(16'h1261, 16'h7FFF, o);
    model_check("post_rst_add", 16'h1261, 16'h7FFF, o);

    // Random operate instructions, biased toward legal encodings.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] r, b;
      r = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 4))
        0: r[15:12] = 4'd1;
        1: r[15:12] = 4'd5;
        2: begin r[15:12] = 4'd9; r[5:0] = 6'h3F; end
        3: r[15:12] = 4'd9;
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) b = 16'h0;
      do_op(r, b, o);
      model_check($sformatf("rnd%0d", i), r, b, o);
    end

    // 17 legal ops with illegal ones interleaved: exercises counter wrap.
    for (int i = 0; i < 17; i++) begin
      do_op(16'h1000 | 16'(i), 16'(i * 3), o);
      model_check($sformatf("wrap%0d", i), 16'h1000 | 16'(i), 16'(i * 3), o);
      if (i % 4 == 0) begin
        do_op(16'hF025, 16'h0, o);
        model_check($sformatf("wrap_ill%0d", i), 16'hF025, 16'h0, o);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
